pump_driver: RTL and testbench

PUMP_DRIVER -- requirements
Module: pump_driver

---
 rtl/pump_driver_pkg.sv | 20 ++
 rtl/pump_driver_cycle_timer.sv | 29 ++
 rtl/pump_driver.sv | 92 +++++++++
 tb/tb_pump_driver.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pump_driver_pkg.sv
// Shared types and constants for the pump dispense controller.
package pump_driver_pkg;

  localparam int CNT_W            = 20;
  localparam int DEF_UNIT_CYCLES  = 125;
  localparam int DEF_GUARD_CYCLES = 50;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  // Timer reload for a dispense: expires after (amount+1)*unit_cycles cycles.
  function automatic logic [CNT_W-1:0] run_load_value(input logic [1:0] amount,
                                                      input int unit_cycles);
    return CNT_W'((int'(amount) + 1) * unit_cycles - 1);
  endfunction

endpackage

// File: rtl/pump_driver_cycle_timer.sv
// Loadable down-counter; expired is high once the count has reached zero.
import pump_driver_pkg::*;

module cycle_timer #(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!RESET) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/pump_driver.sv
// Pump dispense controller: timed pump-on interval followed by a mandatory off guard.
//
// state    | meaning
// ST_IDLE  | waiting for a start request
// ST_RUN   | pump on, dose timer counting
// ST_GUARD | pump off, guard timer counting; requests ignored
import pump_driver_pkg::*;

module pump_driver #(
  parameter int C_UNIT_CYCLES  = DEF_UNIT_CYCLES,
  parameter int C_GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       i_start,
  input  logic [1:0] i_amount,
  input  logic       i_abort,
  output logic       o_pump,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_aborted
);

  state_t             state_q, state_d;
  logic [1:0]         amount_q, amount_d;
  logic               tmr_load, tmr_en, tmr_expired;
  logic [CNT_W-1:0]   tmr_load_value;
  logic               done_d, aborted_d;

  always_ff @(posedge clk) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      amount_q  <= '0;
      o_pump    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_aborted <= 1'b0;
    end else begin
      state_q   <= state_d;
      amount_q  <= amount_d;
      o_pump    <= (state_d == ST_RUN);
      o_busy    <= (state_d != ST_IDLE);
      o_done    <= done_d;
      o_aborted <= aborted_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    amount_d       = amount_q;
    tmr_load       = 1'b0;
    tmr_load_value = run_load_value(amount_d, C_UNIT_CYCLES);
    done_d         = 1'b0;
    aborted_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          state_d        = ST_RUN;
          amount_d       = i_amount;
          tmr_load       = 1'b1;
          tmr_load_value = run_load_value(i_amount, C_UNIT_CYCLES);
        end
      end
      ST_RUN: begin
        // Countdown end takes precedence over a coincident abort.
        if (tmr_expired || i_abort) begin
          state_d        = ST_GUARD;
          tmr_load       = 1'b1;
          tmr_load_value = CNT_W'(C_GUARD_CYCLES - 1);
          done_d         = tmr_expired;
          aborted_d      = !tmr_expired;
        end
      end
      ST_GUARD: begin
        if (tmr_expired) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tmr_en = (state_q == ST_RUN) || (state_q == ST_GUARD);

  cycle_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .RESET      (RESET),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .en         (tmr_en),
    .expired    (tmr_expired)
  );

endmodule

// File: tb/tb_pump_driver.sv
// Self-checking bench for pump_driver: directed table, hand sequences, random run vs timeline model.
module tb_pump_driver;

  localparam int U = 125;
  localparam int G = 50;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] amount;
  logic       abort;
  logic       o_pump, o_busy, o_done, o_aborted;

  int n_tests = 0;
  int n_fail  = 0;

  // Timeline reference model: edge index and scheduled interval boundaries.
  longint k         = 0;
  longint run_start = -100;
  longint run_end   = -100;
  longint free_at   = 0;
  bit     end_normal = 1'b1;

  typedef struct {
    int amt;
    int abort_at;
    int new_amt;
    int poke_at;
    int exp_pump;
    int exp_busy;
    int exp_done;
    int exp_ab;
  } vec_t;

  vec_t tbl[6];

  pump_driver #(.C_UNIT_CYCLES(U), .C_GUARD_CYCLES(G)) dut (
    .clk       (clk),
    .RESET     (rst_n),
    .i_start   (start),
    .i_amount  (amount),
    .i_abort   (abort),
    .o_pump    (o_pump),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_aborted (o_aborted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, k);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      free_at   = k + 1;
      run_start = -100;
      run_end   = -100;
    end else if (k >= free_at) begin
      if (start && !abort) begin
        run_start  = k;
        run_end    = k + (longint'(amount) + 1) * U;
        free_at    = run_end + G + 1;
        end_normal = 1'b1;
      end
    end else if (k > run_start && k < run_end && abort) begin
      run_end    = k;
      free_at    = k + G + 1;
      end_normal = 1'b0;
    end
  endtask

  task automatic step();
    bit ep, eb, ed, ea;
    @(posedge clk);
    model_edge();
    ep = (run_start <= k) && (k < run_end);
    eb = (run_start <= k) && (k <= free_at - 2);
    ed = (k == run_end) && end_normal;
    ea = (k == run_end) && !end_normal;
    #1;
    check_val("outputs{pump,busy,done,aborted}",
              int'({o_pump, o_busy, o_done, o_aborted}), int'({ep, eb, ed, ea}));
    k++;
  endtask

  task automatic drain();
    int n = 0;
    while (o_busy && n < 1200) begin
      step();
      n++;
    end
    check_val("drain_to_idle_busy", int'(o_busy), 0);
    step();
  endtask

  task automatic run_case(input vec_t v, input int idx);
    int p = 0, b = 0, d = 0, a = 0;
    amount = 2'(v.amt);
    start  = 1'b1;
    abort  = 1'b0;
    step();
    p += int'(o_pump); b += int'(o_busy); d += int'(o_done); a += int'(o_aborted);
    start = 1'b0;
    for (int i = 1; i < 650; i++) begin
      abort = (i == v.abort_at);
      start = (i == v.poke_at);
      if (i == 5) amount = 2'(v.new_amt);
      step();
      p += int'(o_pump); b += int'(o_busy); d += int'(o_done); a += int'(o_aborted);
    end
    abort = 1'b0;
    start = 1'b0;
    check_val($sformatf("case%0d_pump_cycles", idx), p, v.exp_pump);
    check_val($sformatf("case%0d_busy_cycles", idx), b, v.exp_busy);
    check_val($sformatf("case%0d_done_pulses", idx), d, v.exp_done);
    check_val($sformatf("case%0d_abort_pulses", idx), a, v.exp_ab);
  endtask

  initial begin
    // amt, abort_at, new_amt, poke_at, pump, busy, done, aborted
    tbl[0] = '{0, -1,  0, 150, 125, 175, 1, 0};
    tbl[1] = '{3, -1,  0,  -1, 500, 550, 1, 0};
    tbl[2] = '{2, 40,  2,  60,  40,  90, 0, 1};
    tbl[3] = '{1, 250, 1,  -1, 250, 300, 1, 0};
    tbl[4] = '{1, 1,   1,  -1,   1,  51, 0, 1};
    tbl[5] = '{0, 125, 3,  -1, 125, 175, 1, 0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; amount = 2'd0;
    repeat (3) step();
    check_val("reset_outputs", int'({o_pump, o_busy, o_done, o_aborted}), 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      run_case(tbl[i], i);
      drain();
    end

    // Start and abort together in IDLE: no dispense.
    start = 1'b1; abort = 1'b1; amount = 2'd2;
    step();
    check_val("start_abort_idle_pump", int'(o_pump), 0);
    check_val("start_abort_idle_busy", int'(o_busy), 0);
    start = 1'b0; abort = 1'b0;
    step();

    // Start held high: repeated 250-on dispenses with at least G off between.
    begin
      int  on_len = 0, off_len = 0, runs = 0;
      bit  prev = 1'b0, seen_fall = 1'b0;
      start = 1'b1; amount = 2'd1;
      for (int i = 0; i < 1000; i++) begin
        step();
        if (o_pump) begin
          if (!prev && seen_fall) begin
            check_val("held_off_at_least_guard", int'(off_len >= G), 1);
            runs++;
          end else if (!prev) begin
            runs++;
          end
          on_len++;
          off_len = 0;
        end else begin
          if (prev) begin
            check_val("held_on_length", on_len, 250);
            seen_fall = 1'b1;
          end
          off_len++;
          on_len = 0;
        end
        prev = o_pump;
      end
      check_val("held_run_count", runs, 4);
      start = 1'b0;
      drain();
    end

    // Reset at RUN cycle 60, then immediate restart.
    start = 1'b1; amount = 2'd2;
    step();
    start = 1'b0;
    for (int i = 1; i < 60; i++) step();
    rst_n = 1'b0;
    step();
    check_val("midrun_reset_outputs", int'({o_pump, o_busy, o_done, o_aborted}), 0);
    rst_n = 1'b1; start = 1'b1; amount = 2'd0;
    step();
    check_val("restart_after_reset_pump", int'(o_pump), 1);
    check_val("restart_after_reset_busy", int'(o_busy), 1);
    start = 1'b0;
    drain();

    // Randomized traffic against the timeline model.
    for (int i = 0; i < 4000; i++) begin
      start  = ($urandom_range(0, 99) < 30);
      abort  = ($urandom_range(0, 99) < 3);
      amount = 2'($urandom_range(0, 3));
      rst_n  = ($urandom_range(0, 999) != 0);
      step();
    end
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
